// File: rtl/fan_tach_period_meter.sv
`default_nettype none
// ============================================================================
//  Module   : fan_tach_period_meter
//  Measures the rising-edge period of a slow asynchronous pulse input.
//  Revision : 1.0
// ============================================================================
module fan_tach_period_meter #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 32,
   parameter int TIMEOUT         = 100_000_000
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_tach,
   output logic             o_edge,
   output logic [CNT_W-1:0] o_period,
   output logic             o_valid,
   output logic             o_timeout
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0]  c_db_last = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_db;
   logic                   r_db_d;
   logic [DB_W-1:0]        r_db_cnt;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       r_idle_cnt;
   logic [CNT_W-1:0]       r_period;
   logic                   r_edge;
   logic                   r_valid;
   logic                   r_timeout;
   state_t                 r_state;

   logic w_sync;
   logic w_rise;

   assign w_sync = r_sync[SYNC_STAGES-1];
   assign w_rise = r_db & ~r_db_d;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_tach};
      end
   end

   // A level change is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_db     <= 1'b0;
         r_db_d   <= 1'b0;
         r_db_cnt <= '0;
      end else begin
         r_db_d <= r_db;
         if (w_sync == r_db) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == c_db_last) begin
            r_db     <= w_sync;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_idle_cnt <= '0;
         r_period   <= '0;
         r_edge     <= 1'b0;
         r_valid    <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_edge  <= w_rise;
         r_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (w_rise) begin
                  r_state    <= MEASURE;
                  r_cnt      <= c_one;
                  r_idle_cnt <= '0;
                  r_timeout  <= 1'b0;
               end else if (r_idle_cnt == c_timeout) begin
                  r_timeout  <= 1'b1;
                  r_period   <= '0;
                  r_idle_cnt <= '0;
               end else begin
                  r_idle_cnt <= r_idle_cnt + 1'b1;
               end
            end
            MEASURE: begin
               // A rise on the timeout cycle takes priority, so a period of exactly TIMEOUT is valid.
               if (w_rise) begin
                  r_period  <= r_cnt;
                  r_valid   <= 1'b1;
                  r_timeout <= 1'b0;
                  r_cnt     <= c_one;
               end else if (r_cnt == c_timeout) begin
                  r_timeout  <= 1'b1;
                  r_period   <= '0;
                  r_cnt      <= '0;
                  r_idle_cnt <= '0;
                  r_state    <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign o_edge    = r_edge;
   assign o_period  = r_period;
   assign o_valid   = r_valid;
   assign o_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_fan_tach_period_meter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fan_tach_period_meter
//  Scoreboard bench: directed tach waveforms, queued expectations, monitor checks.
//  Revision : 1.0
// ============================================================================
module tb_fan_tach_period_meter;

   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 1000;

   logic             i_clk;
   logic             i_reset;
   logic             i_tach;
   logic             o_edge;
   logic [CNT_W-1:0] o_period;
   logic             o_valid;
   logic             o_timeout;

   fan_tach_period_meter #(
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (CNT_W),
      .TIMEOUT        (TIMEOUT)
   ) u_dut (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_tach   (i_tach),
      .o_edge   (o_edge),
      .o_period (o_period),
      .o_valid  (o_valid),
      .o_timeout(o_timeout)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      bit         is_to;
      int         period;
   } exp_t;

   typedef struct {
      int         id;
      int         period;
      bit         to;
      int         edges;
   } snap_t;

   exp_t  q[$];
   snap_t sq[$];

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int last_edge   = 0;
   int edges_seen  = 0;
   int exp_edges   = 0;
   bit prev_to     = 1'b0;
   bit prev_valid  = 1'b0;
   bit prev_edge   = 1'b0;

   // Monitor: compares every DUT output event and every status snapshot request.
   always @(negedge i_clk) begin
      exp_t  e;
      snap_t s;
      cyc = cyc + 1;
      if (o_edge) begin
         edges_seen = edges_seen + 1;
         last_edge  = cyc;
      end
      if ((o_valid && prev_valid) || (o_edge && prev_edge)) begin
         vectors     = vectors + 1;
         miscompares = miscompares + 1;
         $display("FAIL pulse_width: valid=%0b edge=%0b high two cycles, required single-cycle", o_valid, o_edge);
      end
      if (o_valid || (o_timeout && !prev_to)) begin
         vectors = vectors + 1;
         if (q.size() == 0) begin
            miscompares = miscompares + 1;
            $display("FAIL unexpected_event: valid=%0b timeout=%0b period=%0d, required none", o_valid, o_timeout, o_period);
         end else begin
            e = q.pop_front();
            if (o_valid) begin
               if (e.is_to || o_period != CNT_W'(e.period) || o_timeout) begin
                  miscompares = miscompares + 1;
                  $display("FAIL period_valid: got period=%0d timeout=%0b, required is_to=%0b period=%0d timeout=0",
                           o_period, o_timeout, e.is_to, e.period);
               end
            end else begin
               if (!e.is_to || o_period != '0 || (cyc - last_edge) != TIMEOUT) begin
                  miscompares = miscompares + 1;
                  $display("FAIL timeout_event: got period=%0d delay=%0d, required is_to=%0b period=0 delay=%0d",
                           o_period, cyc - last_edge, e.is_to, TIMEOUT);
               end
            end
         end
      end
      while (sq.size() != 0) begin
         s = sq.pop_front();
         vectors = vectors + 1;
         if (o_period != CNT_W'(s.period) || o_timeout != s.to || o_valid || o_edge ||
             (s.edges >= 0 && edges_seen != s.edges)) begin
            miscompares = miscompares + 1;
            $display("FAIL snapshot_%0d: got period=%0d timeout=%0b valid=%0b edge=%0b edges=%0d, required period=%0d timeout=%0b valid=0 edge=0 edges=%0d",
                     s.id, o_period, o_timeout, o_valid, o_edge, edges_seen, s.period, s.to, s.edges);
         end
      end
      prev_to    = o_timeout;
      prev_valid = o_valid;
      prev_edge  = o_edge;
   end

   task automatic hold(input logic lvl, input int n);
      i_tach = lvl;
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic train(input int period, input int n);
      for (int k = 0; k < n; k++) begin
         exp_edges = exp_edges + 1;
         hold(1'b1, period / 2);
         hold(1'b0, period - period / 2);
      end
   endtask

   // 86 cycles on the base level with 1, 2 and 3 cycle glitches to the opposite level.
   task automatic glitch_phase(input logic base);
      for (int g = 1; g <= 3; g++) begin
         hold(base, 20);
         hold(~base, g);
      end
      hold(base, 20);
   endtask

   task automatic push_v(input int period, input int n);
      for (int k = 0; k < n; k++) q.push_back('{is_to: 1'b0, period: period});
   endtask

   task automatic push_t();
      q.push_back('{is_to: 1'b1, period: 0});
   endtask

   task automatic snap(input int id, input int period, input bit to, input int edges);
      sq.push_back('{id: id, period: period, to: to, edges: edges});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      i_reset = 1'b1;
      i_tach  = 1'b0;
      repeat (3) @(posedge i_clk);
      #2 i_reset = 1'b0;
      @(posedge i_clk);
      #1;
      snap(0, 0, 1'b0, 0);

      // Steady 200-cycle square wave: first rise gives no valid.
      push_v(200, 9);
      train(200, 10);
      snap(1, 200, 1'b0, -1);

      // Period changes to 50.
      push_v(200, 1);
      push_v(50, 4);
      train(50, 5);

      // Glitches on a low line, a real rise 136 after the last, glitches on a high line.
      glitch_phase(1'b0);
      snap(2, 50, 1'b0, -1);
      push_v(136, 1);
      exp_edges = exp_edges + 1;
      hold(1'b1, 10);
      glitch_phase(1'b1);
      hold(1'b0, 104);
      snap(3, 136, 1'b0, -1);

      // Stall: timeout 1000 cycles after last rise, then restart at period 300.
      push_v(200, 3);
      push_t();
      train(200, 3);
      hold(1'b0, 1200);
      snap(4, 0, 1'b1, -1);
      push_v(300, 2);
      train(300, 3);

      // Period exactly TIMEOUT, then a stall.
      push_v(300, 1);
      push_v(1000, 2);
      push_t();
      train(1000, 3);
      hold(1'b0, 20);

      // Reset mid-measurement.
      push_v(200, 1);
      train(200, 1);
      exp_edges = exp_edges + 1;
      hold(1'b1, 100);
      hold(1'b0, 20);
      #3 i_reset = 1'b1;
      snap(5, 0, 1'b0, -1);
      repeat (3) @(posedge i_clk);
      #2 i_reset = 1'b0;
      @(posedge i_clk);
      #1;
      push_v(250, 1);
      train(250, 2);
      snap(6, 250, 1'b0, exp_edges);

      for (int w = 0; w < 2000 && (q.size() != 0 || sq.size() != 0); w++) @(posedge i_clk);
      if (q.size() != 0 || sq.size() != 0) begin
         $display("FAIL drain: %0d events and %0d snapshots pending, required 0", q.size(), sq.size());
         $fatal(1, "drain");
      end
      @(negedge i_clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
